// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - SVGA 800x600@60 timing constants and RGB565 types shared with the renderers
package vga_timing_pkg;

  localparam int CNT_W = 11;
  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;

  localparam int SVGA_H_DISP = 800;
  localparam int SVGA_H_FP   = 40;
  localparam int SVGA_H_SYNC = 128;
  localparam int SVGA_H_BP   = 88;
  localparam int SVGA_V_DISP = 600;
  localparam int SVGA_V_FP   = 1;
  localparam int SVGA_V_SYNC = 4;
  localparam int SVGA_V_BP   = 23;

  localparam int SVGA_H_TOTAL      = SVGA_H_DISP + SVGA_H_FP + SVGA_H_SYNC + SVGA_H_BP;
  localparam int SVGA_V_TOTAL      = SVGA_V_DISP + SVGA_V_FP + SVGA_V_SYNC + SVGA_V_BP;
  localparam int SVGA_H_SYNC_START = SVGA_H_DISP + SVGA_H_FP;
  localparam int SVGA_H_SYNC_END   = SVGA_H_SYNC_START + SVGA_H_SYNC - 1;
  localparam int SVGA_V_SYNC_START = SVGA_V_DISP + SVGA_V_FP;
  localparam int SVGA_V_SYNC_END   = SVGA_V_SYNC_START + SVGA_V_SYNC - 1;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb565_t;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one scan axis: wrapping position counter with raw (active-high) sync window
module vga_axis_counter
  import vga_timing_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [CNT_W-1:0] total,
  input  logic [CNT_W-1:0] sync_start,
  input  logic [CNT_W-1:0] sync_end,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             sync
);

  // Compared one bit wider so an out-of-range count (or total of 0) still wraps.
  assign wrap = ({1'b0, cnt} + (CNT_W+1)'(1)) >= {1'b0, total};
  assign sync = (cnt >= sync_start) && (cnt <= sync_end);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - pixel scan, sync generation, blanking and registered VGA pins
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISP   = SVGA_H_DISP,
  parameter int H_FP     = SVGA_H_FP,
  parameter int H_SYNC   = SVGA_H_SYNC,
  parameter int H_BP     = SVGA_H_BP,
  parameter int V_DISP   = SVGA_V_DISP,
  parameter int V_FP     = SVGA_V_FP,
  parameter int V_SYNC   = SVGA_V_SYNC,
  parameter int V_BP     = SVGA_V_BP,
  parameter int SYNC_POL = 1,
  parameter int CLK_DIV  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             video_on,
  output logic             pix_tick,
  output logic             line_tick,
  output logic             frame_tick,
  input  logic [R_W-1:0]   rgb_r_in,
  input  logic [G_W-1:0]   rgb_g_in,
  input  logic [B_W-1:0]   rgb_b_in,
  output logic [R_W-1:0]   vga_r,
  output logic [G_W-1:0]   vga_g,
  output logic [B_W-1:0]   vga_b,
  output logic             vga_hs,
  output logic             vga_vs
);

  localparam logic [CNT_W-1:0] H_DISP_C  = CNT_W'(H_DISP);
  localparam logic [CNT_W-1:0] V_DISP_C  = CNT_W'(V_DISP);
  localparam logic [CNT_W-1:0] H_TOTAL_C = CNT_W'(H_DISP + H_FP + H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] V_TOTAL_C = CNT_W'(V_DISP + V_FP + V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] H_SS_C    = CNT_W'(H_DISP + H_FP);
  localparam logic [CNT_W-1:0] H_SE_C    = CNT_W'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_SS_C    = CNT_W'(V_DISP + V_FP);
  localparam logic [CNT_W-1:0] V_SE_C    = CNT_W'(V_DISP + V_FP + V_SYNC - 1);

  localparam int DIV_W = 2;
  localparam int DIV_EFF = (CLK_DIV < 1) ? 1 : ((CLK_DIV > 4) ? 4 : CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_EFF - 1);
  localparam logic SYNC_ACT = (SYNC_POL != 0);

  logic             run;
  logic [DIV_W-1:0] div;
  logic             h_wrap, v_wrap, h_sync, v_sync;
  rgb565_t          pix_in, pin_rgb;

  // run holds the divider for one clk after reset release, so the first
  // pix_tick lands CLK_DIV clks after reset_n rises for any divide ratio.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run <= 1'b0;
      div <= '0;
    end else begin
      run <= 1'b1;
      if (run) begin
        div <= (div >= DIV_LAST) ? '0 : div + DIV_W'(1);
      end
    end
  end

  assign pix_tick = run && (div == DIV_LAST);

  vga_axis_counter u_h (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (pix_tick),
    .total      (H_TOTAL_C),
    .sync_start (H_SS_C),
    .sync_end   (H_SE_C),
    .cnt        (pix_x),
    .wrap       (h_wrap),
    .sync       (h_sync)
  );

  vga_axis_counter u_v (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (pix_tick && h_wrap),
    .total      (V_TOTAL_C),
    .sync_start (V_SS_C),
    .sync_end   (V_SE_C),
    .cnt        (pix_y),
    .wrap       (v_wrap),
    .sync       (v_sync)
  );

  assign video_on = (pix_x < H_DISP_C) && (pix_y < V_DISP_C);
  assign pix_in   = {rgb_r_in, rgb_g_in, rgb_b_in};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      line_tick  <= pix_tick && h_wrap;
      frame_tick <= pix_tick && h_wrap && v_wrap;
    end
  end

  // Pins capture the current pixel's context, so they trail pix_x/pix_y by one pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pin_rgb <= '0;
      vga_hs  <= ~SYNC_ACT;
      vga_vs  <= ~SYNC_ACT;
    end else if (pix_tick) begin
      pin_rgb <= video_on ? pix_in : '0;
      vga_hs  <= h_sync ? SYNC_ACT : ~SYNC_ACT;
      vga_vs  <= v_sync ? SYNC_ACT : ~SYNC_ACT;
    end
  end

  assign vga_r = pin_rgb.r;
  assign vga_g = pin_rgb.g;
  assign vga_b = pin_rgb.b;

endmodule
